// File: rtl/text_console_ctrl.sv
// Text console controller: turns a stream of ASCII characters into writes to a
// COLS x ROWS character buffer, with cursor tracking and a full-screen clear.
module text_console_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    input  logic        clr_req,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam int          DEPTH     = COLS * ROWS;
    localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE
    } state_t;

    state_t      state, state_n;
    logic [11:0] clr_ptr, clr_ptr_n;
    logic [11:0] cur_addr;
    logic [4:0]  line_row;
    logic        wr_en_n;
    logic [11:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic [6:0]  col_n;
    logic [4:0]  row_n;

    assign cur_addr = {7'd0, cursor_row} * 12'(COLS) + {5'd0, cursor_col};
    assign line_row = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    assign ch_ready = (state == IDLE) && !clr_req;
    assign busy     = (state == CLEAR);

    always_comb begin
        state_n   = state;
        clr_ptr_n = clr_ptr;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        col_n     = cursor_col;
        row_n     = cursor_row;
        case (state)
            CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = clr_ptr;
                wr_data_n = SPACE;
                if (clr_ptr == LAST_ADDR) begin
                    clr_ptr_n = 12'd0;
                    state_n   = IDLE;
                end else begin
                    clr_ptr_n = clr_ptr + 12'd1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_n   = CLEAR;
                    clr_ptr_n = 12'd0;
                    col_n     = 7'd0;
                    row_n     = 5'd0;
                end else if (ch_valid) begin
                    state_n = WRITE;
                    if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = cur_addr;
                        wr_data_n = ch_data;
                        if (cursor_col == LAST_COL) begin
                            col_n = 7'd0;
                            row_n = line_row;
                        end else begin
                            col_n = cursor_col + 7'd1;
                        end
                    end else if (ch_data == 8'h0A || ch_data == 8'h0D) begin
                        col_n = 7'd0;
                        row_n = line_row;
                    end else if (ch_data == 8'h08) begin
                        // Stepping back one cell is always cur_addr-1, also across a row boundary.
                        if (cursor_col != 7'd0 || cursor_row != 5'd0) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = cur_addr - 12'd1;
                            wr_data_n = SPACE;
                            if (cursor_col != 7'd0) begin
                                col_n = cursor_col - 7'd1;
                            end else begin
                                col_n = LAST_COL;
                                row_n = cursor_row - 5'd1;
                            end
                        end
                    end else if (ch_data == 8'h0C) begin
                        state_n   = CLEAR;
                        clr_ptr_n = 12'd0;
                        col_n     = 7'd0;
                        row_n     = 5'd0;
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            clr_ptr    <= 12'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 12'd0;
            wr_data    <= SPACE;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
        end else begin
            state      <= state_n;
            clr_ptr    <= clr_ptr_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
        end
    end

endmodule
